// File: rtl/af_pkg.sv
// Shared types and default sizes for the autofocus sweep controller.
// Optional settle-frame behaviour is enabled with AF_SETTLE_EN (see af_sweep_ctrl).
package af_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COARSE,
      S_FINE,
      S_PARK
   } af_state_t;

   localparam int          STEP_W_DEF   = 11;
   localparam int          METRIC_W_DEF = 24;
   localparam logic [10:0] STEP_MAX_DEF = 11'h3F0;

endpackage

// File: rtl/af_peak_track.sv
// Sharpness peak tracker: keeps the best metric seen and the step where it occurred.
// peak_upd exposes the peak including the sample being taken this cycle.
module af_peak_track
   import af_pkg::*;
#(
   parameter int STEP_W   = STEP_W_DEF,
   parameter int METRIC_W = METRIC_W_DEF
)(
   input  logic                CLK,
   input  logic                RESET_n,
   input  logic                clear,
   input  logic                sample,
   input  logic [METRIC_W-1:0] metric,
   input  logic [STEP_W-1:0]   step,
   output logic [STEP_W-1:0]   peak_step,
   output logic [STEP_W-1:0]   peak_upd
);

   logic [METRIC_W-1:0] best_metric;
   logic                better;

   // Strictly greater only, so on a tie the earlier step is kept
   assign better   = sample && (metric > best_metric);
   assign peak_upd = better ? step : peak_step;

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         best_metric <= '0;
         peak_step   <= '0;
      end else if (clear) begin
         best_metric <= '0;
         peak_step   <= '0;
      end else if (better) begin
         best_metric <= metric;
         peak_step   <= step;
      end
   end

endmodule

// File: rtl/af_sweep_ctrl.sv
// Autofocus VCM sweep: coarse pass, fine pass around the coarse peak, then park at the peak.
// Define AF_SETTLE_EN to discard the first frame after every STEP change.
module af_sweep_ctrl
   import af_pkg::*;
#(
   parameter int                STEP_W   = STEP_W_DEF,
   parameter int                METRIC_W = METRIC_W_DEF,
   parameter logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_MAX_DEF)
)(
   input  logic                CLK,
   input  logic                RESET_n,
   input  logic                START,
   input  logic                ABORT,
   input  logic                VS,
   input  logic [METRIC_W-1:0] METRIC,
   input  logic [7:0]          SCAL,
   input  logic [7:0]          SCAL_F,
   output logic [STEP_W-1:0]   STEP,
   output logic                BUSY,
   output logic                DONE,
   output logic [STEP_W-1:0]   PEAK_STEP,
   output logic                FINE
);

   localparam int XW = STEP_W + 1;

   af_state_t         state, state_nxt;
   logic [STEP_W-1:0] step_nxt, fine_end, fine_end_nxt, peak_upd;
   logic [XW-1:0]     coarse_sum, fine_sum, half, peak_ext, fine_lo, fine_hi, max_ext;
   logic              coarse_last, fine_last, vs_act, discard, sample, clear, step_load, done_nxt;

   af_peak_track #(.STEP_W(STEP_W), .METRIC_W(METRIC_W)) u_peak (
      .CLK       (CLK),
      .RESET_n   (RESET_n),
      .clear     (clear),
      .sample    (sample),
      .metric    (METRIC),
      .step      (STEP),
      .peak_step (PEAK_STEP),
      .peak_upd  (peak_upd)
   );

`ifdef AF_SETTLE_EN
   logic settle_pending;

   // Any STEP load arms a discard of the next frame while the lens settles
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n)
         settle_pending <= 1'b0;
      else if (step_load)
         settle_pending <= 1'b1;
      else if (VS && !ABORT)
         settle_pending <= 1'b0;
   end

   assign discard = settle_pending;
`else
   assign discard = 1'b0;
`endif

   assign vs_act = VS && !ABORT && !discard;
   assign sample = vs_act && ((state == S_COARSE) || (state == S_FINE));

   // Arithmetic is one bit wider than STEP so nothing can wrap past STEP_MAX
   assign max_ext     = {1'b0, STEP_MAX};
   assign coarse_sum  = {1'b0, STEP} + {{(XW-8){1'b0}}, SCAL};
   assign fine_sum    = {1'b0, STEP} + {{(XW-8){1'b0}}, SCAL_F};
   assign half        = {{(XW-7){1'b0}}, SCAL[7:1]};
   assign peak_ext    = {1'b0, peak_upd};
   assign fine_lo     = (peak_ext >= half) ? (peak_ext - half) : '0;
   assign fine_hi     = peak_ext + half;
   assign coarse_last = (SCAL == 8'd0) || (coarse_sum > max_ext);
   assign fine_last   = (SCAL_F == 8'd0) || (STEP >= fine_end) || (fine_sum > {1'b0, fine_end});

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ABORT)
         state_nxt = S_IDLE;
      else begin
         case (state)
            S_IDLE:   if (START)                 state_nxt = S_COARSE;
            S_COARSE: if (vs_act && coarse_last) state_nxt = S_FINE;
            S_FINE:   if (vs_act && fine_last)   state_nxt = S_PARK;
            S_PARK:   if (vs_act)                state_nxt = S_IDLE;
            default:                             state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      step_nxt     = STEP;
      fine_end_nxt = fine_end;
      step_load    = 1'b0;
      clear        = 1'b0;
      done_nxt     = 1'b0;
      if (!ABORT) begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  clear     = 1'b1;
                  step_load = 1'b1;
                  step_nxt  = '0;
               end
            end
            S_COARSE: begin
               if (vs_act) begin
                  step_load = 1'b1;
                  if (coarse_last) begin
                     step_nxt     = fine_lo[STEP_W-1:0];
                     fine_end_nxt = (fine_hi > max_ext) ? STEP_MAX : fine_hi[STEP_W-1:0];
                  end else
                     step_nxt = coarse_sum[STEP_W-1:0];
               end
            end
            S_FINE: begin
               if (vs_act) begin
                  step_load = 1'b1;
                  step_nxt  = fine_last ? peak_upd : fine_sum[STEP_W-1:0];
               end
            end
            S_PARK: done_nxt = vs_act;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         STEP     <= '0;
         fine_end <= '0;
         DONE     <= 1'b0;
         BUSY     <= 1'b0;
         FINE     <= 1'b0;
      end else begin
         if (step_load)
            STEP <= step_nxt;
         fine_end <= fine_end_nxt;
         DONE     <= done_nxt;
         BUSY     <= (state_nxt != S_IDLE);
         FINE     <= (state_nxt == S_FINE);
      end
   end

endmodule

// File: tb/tb_af_sweep_ctrl.sv
// Scoreboard bench for af_sweep_ctrl: a sweep model predicts every frame position and the final peak.
// Build with AF_SETTLE_EN defined to exercise discard frames.
module tb_af_sweep_ctrl;

   localparam int STEP_MAX = 1008;

   logic        CLK = 1'b0;
   logic        RESET_n, START, ABORT, VS;
   logic [23:0] METRIC;
   logic [7:0]  SCAL, SCAL_F;
   logic [10:0] STEP, PEAK_STEP;
   logic        BUSY, DONE, FINE;

   int checks = 0;
   int errors = 0;
   int exp_step_q[$];
   int exp_peak_q[$];
   int plan_q[$];
   int plan_peak;
   int done_seen = 0;
   int done_expected = 0;
   int prof_mode, prof_peak;
   bit settle = 1'b0;

   af_sweep_ctrl dut (
      .CLK(CLK), .RESET_n(RESET_n), .START(START), .ABORT(ABORT), .VS(VS),
      .METRIC(METRIC), .SCAL(SCAL), .SCAL_F(SCAL_F), .STEP(STEP), .BUSY(BUSY),
      .DONE(DONE), .PEAK_STEP(PEAK_STEP), .FINE(FINE)
   );

   always #5 CLK = ~CLK;

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Sharpness as a camera would report it at a lens position
   function automatic int metric_at(input int s);
      int d;
      int v;
      if (prof_mode == 1)
         return (s == 200 || s == 300) ? 5000 : 100;
      d = (s > prof_peak) ? s - prof_peak : prof_peak - s;
      v = 1000000 - d * 100;
      return (v < 1) ? 1 : v;
   endfunction

   // Walk the sweep rules to list every lens position that gets a frame
   task automatic model_plan(input int scal, input int scalf);
      int best, peak, s, h, fend, m;
      plan_q.delete();
      best = 0;
      peak = 0;
      s    = 0;
      while (1) begin
         plan_q.push_back(s);
         m = metric_at(s);
         if (m > best) begin best = m; peak = s; end
         if (scal == 0 || s + scal > STEP_MAX) break;
         s += scal;
      end
      h    = scal / 2;
      s    = (peak >= h) ? peak - h : 0;
      fend = (peak + h > STEP_MAX) ? STEP_MAX : peak + h;
      while (1) begin
         plan_q.push_back(s);
         m = metric_at(s);
         if (m > best) begin best = m; peak = s; end
         if (scalf == 0 || s >= fend || s + scalf > fend) break;
         s += scalf;
      end
      plan_q.push_back(peak);
      plan_peak = peak;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_frame(input int pos, input bit discard_frame);
      exp_step_q.push_back(pos);
      VS     = 1'b1;
      METRIC = discard_frame ? 24'hFFFFFF : 24'(metric_at(pos));
      tick();
      VS     = 1'b0;
      METRIC = 24'($urandom);
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic send_position(input int pos);
      if (settle) send_frame(pos, 1'b1);
      send_frame(pos, 1'b0);
   endtask

   task automatic pulse_start(input int scal, input int scalf);
      SCAL   = 8'(scal);
      SCAL_F = 8'(scalf);
      START  = 1'b1;
      tick();
      START  = 1'b0;
      tick();
   endtask

   // Full sweep: model predicts positions and final peak, driver feeds frames
   task automatic apply_stimulus(input int scal, input int scalf, input int mode, input int peak);
      int n;
      prof_mode = mode;
      prof_peak = peak;
      model_plan(scal, scalf);
      exp_peak_q.push_back(plan_peak);
      done_expected++;
      pulse_start(scal, scalf);
      foreach (plan_q[i]) send_position(plan_q[i]);
      n = 0;
      while (BUSY && n < 20) begin tick(); n++; end
      check_output("sweep_end_busy", int'(BUSY), 0);
   endtask

   // Monitor: every accepted frame and every DONE pulse is checked against the queues
   always @(negedge CLK) begin
      int e;
      if (RESET_n) begin
         if (VS && BUSY && !ABORT) begin
            if (exp_step_q.size() == 0)
               check_output("frame_unexpected", int'(STEP), -1);
            else begin
               e = exp_step_q.pop_front();
               check_output("frame_step", int'(STEP), e);
               check_output("step_max", int'(STEP > 11'(STEP_MAX)), 0);
            end
         end
         if (DONE) begin
            done_seen++;
            if (exp_peak_q.size() == 0)
               check_output("done_unexpected", int'(PEAK_STEP), -1);
            else begin
               e = exp_peak_q.pop_front();
               check_output("done_peak", int'(PEAK_STEP), e);
               check_output("done_step", int'(STEP), e);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int scal, scalf;
`ifdef AF_SETTLE_EN
      settle = 1'b1;
`endif
      RESET_n = 1'b0;
      START = 1'b0; ABORT = 1'b0; VS = 1'b0;
      METRIC = '0; SCAL = '0; SCAL_F = '0;
      repeat (3) tick();
      check_output("reset_step", int'(STEP), 0);
      check_output("reset_peak", int'(PEAK_STEP), 0);
      check_output("reset_busy", int'(BUSY), 0);
      check_output("reset_done", int'(DONE), 0);
      check_output("reset_fine", int'(FINE), 0);
      RESET_n = 1'b1;
      tick();

      // Coarse/fine sweep with peak at 500
      apply_stimulus(100, 10, 0, 500);
      check_output("coarse_final_step", int'(STEP), 500);
      check_output("coarse_final_peak", int'(PEAK_STEP), 500);

      // Clamp at both ends of the range
      apply_stimulus(100, 10, 0, 0);
      check_output("clamp_low_peak", int'(PEAK_STEP), 0);
      apply_stimulus(100, 10, 0, 1000);
      check_output("clamp_high_peak", int'(PEAK_STEP), 1000);

      // Tie keeps the earlier step
      apply_stimulus(100, 10, 1, 0);
      check_output("tie_peak", int'(PEAK_STEP), 200);

      // Zero increments terminate each pass on its first frame
      apply_stimulus(0, 0, 0, 300);
      check_output("zero_inc_peak", int'(PEAK_STEP), 0);

      // Abort coincident with a fine frame at 470
      prof_mode = 0;
      prof_peak = 500;
      model_plan(100, 10);
      pulse_start(100, 10);
      for (int i = 0; i < 13; i++) send_position(plan_q[i]);
      check_output("abort_pre_fine", int'(FINE), 1);
      ABORT  = 1'b1;
      VS     = 1'b1;
      METRIC = 24'hFFFFFF;
      tick();
      ABORT = 1'b0;
      VS    = 1'b0;
      check_output("abort_busy", int'(BUSY), 0);
      check_output("abort_fine", int'(FINE), 0);
      check_output("abort_step", int'(STEP), 470);
      check_output("abort_peak", int'(PEAK_STEP), 500);
      repeat (3) tick();
      apply_stimulus(100, 10, 0, 500);

      // Reset mid-coarse at step 300
      prof_mode = 0;
      prof_peak = 700;
      pulse_start(100, 10);
      for (int i = 0; i < 3; i++) send_position(i * 100);
      check_output("pre_reset_step", int'(STEP), 300);
      RESET_n = 1'b0;
      #1;
      check_output("midreset_step", int'(STEP), 0);
      check_output("midreset_peak", int'(PEAK_STEP), 0);
      check_output("midreset_busy", int'(BUSY), 0);
      check_output("midreset_done", int'(DONE), 0);
      check_output("midreset_fine", int'(FINE), 0);
      tick();
      RESET_n = 1'b1;
      tick();

      // Randomized sweeps
      for (int k = 0; k < 8; k++) begin
         scal  = $urandom_range(20, 255);
         scalf = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
         apply_stimulus(scal, scalf, 0, $urandom_range(0, STEP_MAX));
      end

      repeat (5) tick();
      check_output("done_count", done_seen, done_expected);
      check_output("frames_left", exp_step_q.size(), 0);
      check_output("peaks_left", exp_peak_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
